// File: rtl/teatimer_pkg.sv
// Tea timer shared types: controller states, pixel layout and colour constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package teatimer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Framebuffer layout: three bytes per LED, sent in G, R, B order.
  localparam int BYTES_PER_LED = 3;

  localparam logic [7:0] LED_ON_LEVEL  = 8'h20;
  localparam logic [7:0] LED_OFF_LEVEL = 8'h00;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  // Colour of one LED given the controller state, whether the countdown
  // bar covers it, and the current flash phase.
  function automatic pixel_t pixel_color(input state_t st, input logic lit, input logic phase_on);
    pixel_t px;
    px.g = LED_OFF_LEVEL;
    px.r = LED_OFF_LEVEL;
    px.b = LED_OFF_LEVEL;
    case (st)
      RUNNING: if (lit) px.g = LED_ON_LEVEL;
      DONE:    if (phase_on) px.r = LED_ON_LEVEL;
      default: ;
    endcase
    return px;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Switch conditioner: 2-flop synchronizer, stability filter, rising-edge press pulse.
// Latency: level change to press pulse = 2 + DEBOUNCE_CYC cycles.
// Backpressure: none; press is a single-cycle pulse the consumer must take.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 200_000
) (
  input  logic clk_20M,
  input  logic resetn,
  input  logic sw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level_q;
  logic [CW-1:0] stable_cnt;

  // Bring the raw switch into the clock domain.
  always_ff @(posedge clk_20M or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it differs from the accepted one for
  // DEBOUNCE_CYC consecutive cycles; pulse on an accepted 0->1 change.
  always_ff @(posedge clk_20M or negedge resetn) begin
    if (!resetn) begin
      level_q    <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else if (sync_q2 == level_q) begin
      stable_cnt <= '0;
      press      <= 1'b0;
    end else if (stable_cnt == CNT_LAST) begin
      level_q    <= sync_q2;
      stable_cnt <= '0;
      press      <= sync_q2;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
      press      <= 1'b0;
    end
  end

endmodule

// File: rtl/teatimer_ctrl.sv
// Tea-brew countdown controller and sole writer of the neopixel framebuffer BRAM.
// Latency: press -> state next edge; repaint sweep starts the cycle after its trigger.
// Backpressure: none; triggers during a sweep collapse into one pending repaint.
module teatimer_ctrl
  import teatimer_pkg::*;
#(
  parameter int NUM_LEDS     = 24,
  parameter int BREW_SECS    = 240,
  parameter int TICK_DIV     = 20_000_000,
  parameter int DEBOUNCE_CYC = 200_000
) (
  input  logic       clk_20M,
  input  logic       resetn,
  input  logic       sw_start,
  input  logic       sw_stop,
  output logic [8:0] w_addr,
  output logic [7:0] din,
  output logic       write_en,
  output logic       busy,
  output logic       done
);

  localparam int              NUM_BYTES = BYTES_PER_LED * NUM_LEDS;
  localparam logic [8:0]      LAST_ADDR = 9'(NUM_BYTES - 1);
  localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [11:0]     BREW_LOAD = 12'(BREW_SECS);
  localparam logic [31:0]     ACC_STEP  = 32'(BREW_SECS);
  localparam logic [31:0]     LED_SCALE = 32'(NUM_LEDS);

  logic          start_press;
  logic          stop_press;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          tick_clr;

  state_t        state;
  state_t        state_nxt;
  logic [11:0]   remaining;
  logic [11:0]   remaining_nxt;
  logic          phase_on;
  logic          phase_nxt;
  logic          repaint;
  logic          pending;

  logic          sweep_last;
  logic          sweep_go;
  logic          sweep_step;
  logic [1:0]    byte_idx;
  logic [31:0]   led_acc;
  logic [31:0]   acc_cand;
  logic [31:0]   rem_scaled;
  logic          lit;
  pixel_t        pix_nxt;
  logic [7:0]    r_q;
  logic [7:0]    b_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
    .clk_20M (clk_20M),
    .resetn  (resetn),
    .sw      (sw_start),
    .press   (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_stop_db (
    .clk_20M (clk_20M),
    .resetn  (resetn),
    .sw      (sw_stop),
    .press   (stop_press)
  );

  assign tick = (tick_cnt == TICK_LAST);
  assign busy = write_en;
  assign done = (state == DONE);

  // 1 s time base: wraps every TICK_DIV cycles, realigned by every start.
  always_ff @(posedge clk_20M or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (tick_clr || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Controller state register.
  always_ff @(posedge clk_20M or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      remaining <= '0;
      phase_on  <= 1'b1;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      phase_on  <= phase_nxt;
    end
  end

  // Next state with stop > start > tick; flags a repaint on every visible change.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    phase_nxt     = phase_on;
    tick_clr      = 1'b0;
    repaint       = 1'b0;
    if (stop_press) begin
      state_nxt     = IDLE;
      remaining_nxt = '0;
      phase_nxt     = 1'b1;
      repaint       = (state != IDLE);
    end else if (start_press) begin
      state_nxt     = RUNNING;
      remaining_nxt = BREW_LOAD;
      phase_nxt     = 1'b1;
      tick_clr      = 1'b1;
      repaint       = 1'b1;
    end else if (tick) begin
      case (state)
        RUNNING: begin
          remaining_nxt = remaining - 12'd1;
          repaint       = 1'b1;
          if (remaining == 12'd1) begin
            state_nxt = DONE;
            phase_nxt = 1'b1;
          end
        end
        DONE: begin
          phase_nxt = !phase_on;
          repaint   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sweep sequencing and per-LED colour; the bar test uses a running
  // i*BREW_SECS accumulator against remaining*NUM_LEDS instead of a divider.
  always_comb begin
    sweep_last = write_en && (w_addr == LAST_ADDR);
    sweep_go   = (!write_en || sweep_last) && (pending || repaint);
    sweep_step = write_en && !sweep_last;
    acc_cand   = sweep_go ? 32'd0 : (led_acc + ACC_STEP);
    rem_scaled = 32'(remaining_nxt) * LED_SCALE;
    lit        = (acc_cand < rem_scaled);
    pix_nxt    = pixel_color(state_nxt, lit, phase_nxt);
  end

  // Remember a repaint that could not start immediately; reset leaves one set
  // so the framebuffer is cleared right after reset.
  always_ff @(posedge clk_20M or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b1;
    end else if (sweep_go) begin
      pending <= 1'b0;
    end else if (repaint) begin
      pending <= 1'b1;
    end
  end

  // Framebuffer write port: one byte per cycle, colour latched at each G byte.
  always_ff @(posedge clk_20M or negedge resetn) begin
    if (!resetn) begin
      write_en <= 1'b0;
      w_addr   <= '0;
      din      <= '0;
      byte_idx <= '0;
      led_acc  <= '0;
      r_q      <= '0;
      b_q      <= '0;
    end else if (sweep_go) begin
      write_en <= 1'b1;
      w_addr   <= '0;
      byte_idx <= '0;
      led_acc  <= '0;
      din      <= pix_nxt.g;
      r_q      <= pix_nxt.r;
      b_q      <= pix_nxt.b;
    end else if (sweep_step) begin
      w_addr <= w_addr + 9'd1;
      if (byte_idx == 2'd2) begin
        byte_idx <= '0;
        led_acc  <= acc_cand;
        din      <= pix_nxt.g;
        r_q      <= pix_nxt.r;
        b_q      <= pix_nxt.b;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        din      <= (byte_idx == 2'd0) ? r_q : b_q;
      end
    end else begin
      write_en <= 1'b0;
      w_addr   <= '0;
      din      <= '0;
      byte_idx <= '0;
      led_acc  <= '0;
    end
  end

endmodule

// File: tb/tb_teatimer_ctrl.sv
// Randomized scoreboard bench for teatimer_ctrl with a behavioural reference model.
// Latency: model predicts every framebuffer write cycle-exactly.
// Backpressure: n/a.
module tb_teatimer_ctrl;

  localparam int N      = 4;
  localparam int BREW   = 4;
  localparam int TDIV   = 10;
  localparam int DEB    = 2;
  localparam int NBYTES = 3 * N;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic       clk_20M  = 1'b0;
  logic       resetn   = 1'b0;
  logic       sw_start = 1'b0;
  logic       sw_stop  = 1'b0;
  logic [8:0] w_addr;
  logic [7:0] din;
  logic       write_en;
  logic       busy;
  logic       done;

  teatimer_ctrl #(
    .NUM_LEDS     (N),
    .BREW_SECS    (BREW),
    .TICK_DIV     (TDIV),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk_20M  (clk_20M),
    .resetn   (resetn),
    .sw_start (sw_start),
    .sw_stop  (sw_stop),
    .w_addr   (w_addr),
    .din      (din),
    .write_en (write_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_20M = ~clk_20M;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int addr;
    int dat;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;

  int  m_mode, m_rem, m_tcnt, m_pos;
  bit  m_phase, m_pending;
  int  m_col[3];
  logic [DEB+1:0] st_h, sp_h;   // bit k = switch sampled k edges ago
  bit  st_lvl, sp_lvl, st_press, sp_press;

  // A switch level is accepted once the synchronized samples covering the
  // last DEB cycles (two edges of synchronizer delay) all show the new level.
  function automatic bit settles(input logic [DEB+1:0] h, input bit lvl);
    return h[DEB+1:2] == {DEB{~lvl}};
  endfunction

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_rem     = 0;
    m_tcnt    = 0;
    m_pos     = -1;
    m_phase   = 1'b1;
    m_pending = 1'b1;
    m_col     = '{0, 0, 0};
    st_h      = '0;
    sp_h      = '0;
    st_lvl    = 1'b0;
    sp_lvl    = 1'b0;
    st_press  = 1'b0;
    sp_press  = 1'b0;
  endtask

  // Called once per rising edge: applies the events of the cycle that just
  // ended and predicts the write (if any) for the cycle that begins.
  task automatic model_step();
    bit tick;
    bit rep;
    int led;
    cyc++;
    if (!resetn) begin
      model_reset();
      exp_q.delete();
      return;
    end
    tick = (m_tcnt == TDIV - 1);
    rep  = 1'b0;
    if (sp_press) begin
      if (m_mode != M_IDLE) rep = 1'b1;
      m_mode = M_IDLE;
      m_rem  = 0;
    end else if (st_press) begin
      m_mode = M_RUN;
      m_rem  = BREW;
      rep    = 1'b1;
    end else if (tick && m_mode == M_RUN) begin
      m_rem = m_rem - 1;
      rep   = 1'b1;
      if (m_rem == 0) begin
        m_mode  = M_DONE;
        m_phase = 1'b1;
      end
    end else if (tick && m_mode == M_DONE) begin
      m_phase = !m_phase;
      rep     = 1'b1;
    end
    m_tcnt = ((st_press && !sp_press) || tick) ? 0 : m_tcnt + 1;

    if ((m_pos < 0 || m_pos == NBYTES - 1) && (m_pending || rep)) begin
      m_pos     = 0;
      m_pending = 1'b0;
    end else begin
      m_pending = m_pending || rep;
      m_pos     = (m_pos >= 0 && m_pos < NBYTES - 1) ? m_pos + 1 : -1;
    end

    if (m_pos >= 0) begin
      if (m_pos % 3 == 0) begin
        led   = m_pos / 3;
        m_col = '{0, 0, 0};
        if (m_mode == M_RUN && led * BREW < m_rem * N) m_col[0] = 32'h20;
        if (m_mode == M_DONE && m_phase) m_col[1] = 32'h20;
      end
      exp_q.push_back('{cyc: cyc, addr: m_pos, dat: m_col[m_pos % 3]});
    end

    st_h     = {st_h[DEB:0], sw_start};
    sp_h     = {sp_h[DEB:0], sw_stop};
    st_press = 1'b0;
    sp_press = 1'b0;
    if (settles(st_h, st_lvl)) begin
      st_lvl   = !st_lvl;
      st_press = st_lvl;
    end
    if (settles(sp_h, sp_lvl)) begin
      sp_lvl   = !sp_lvl;
      sp_press = sp_lvl;
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  task automatic monitor_step();
    bit exp_wr;
    if (!resetn) return;
    exp_wr = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("write_en", 32'(write_en), 32'(exp_wr));
    check("busy", 32'(busy), 32'(exp_wr));
    check("done", 32'(done), 32'(m_mode == M_DONE));
    if (exp_wr) begin
      if (write_en) begin
        check("w_addr", 32'(w_addr), 32'(exp_q[0].addr));
        check("din", 32'(din), 32'(exp_q[0].dat));
      end
      void'(exp_q.pop_front());
    end
  endtask

  initial forever begin
    @(posedge clk_20M);
    model_step();
  end

  initial forever begin
    @(negedge clk_20M);
    monitor_step();
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_20M);
  endtask

  task automatic pulse(input bit s, input bit p, input int hold);
    @(negedge clk_20M);
    sw_start = s;
    sw_stop  = p;
    repeat (hold) @(negedge clk_20M);
    sw_start = 1'b0;
    sw_stop  = 1'b0;
    idle(4);
  endtask

  initial begin
    bit found;

    // Reset state
    repeat (3) @(posedge clk_20M);
    #2;
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    idle(20);

    // Clean start, run the whole countdown into DONE and watch it flash
    pulse(1'b1, 1'b0, 4);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk_20M);
    check("done_reached", 32'(done), 32'd1);
    idle(45);

    // Stop from DONE
    pulse(1'b0, 1'b1, 4);
    idle(20);

    // Stop and start accepted in the same cycle while RUNNING
    pulse(1'b1, 1'b0, 4);
    idle(15);
    pulse(1'b1, 1'b1, 4);
    idle(20);
    check("stop_wins_done", 32'(done), 32'd0);

    // Bouncing start switch, then a solid hold
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_20M);
      sw_start = (i % 2 == 0);
    end
    @(negedge clk_20M);
    sw_start = 1'b1;
    idle(10);
    sw_start = 1'b0;
    idle(40);
    pulse(1'b0, 1'b1, 4);
    idle(10);

    // Random mix of presses, glitches, coincident presses and idle gaps
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: pulse(1'b1, 1'b0, int'($urandom_range(1, 5)));
        1: pulse(1'b0, 1'b1, int'($urandom_range(1, 5)));
        2: pulse(1'b1, 1'b1, int'($urandom_range(2, 5)));
        3: idle(int'($urandom_range(1, 30)));
        default: begin
          for (int k = 0; k < 8; k++) begin
            @(negedge clk_20M);
            sw_start = 1'($urandom_range(0, 1));
          end
          @(negedge clk_20M);
          sw_start = 1'b0;
        end
      endcase
      idle(int'($urandom_range(0, 8)));
    end
    idle(20);

    // Reset asserted in the middle of a sweep
    pulse(1'b1, 1'b0, 4);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk_20M);
      #1;
      if (write_en && w_addr == 9'd5) found = 1'b1;
    end
    check("sweep_addr5_seen", 32'(found), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("arst_write_en", 32'(write_en), 32'd0);
    check("arst_w_addr", 32'(w_addr), 32'd0);
    check("arst_din", 32'(din), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk_20M);
    #2 resetn = 1'b1;
    idle(20);
    pulse(1'b1, 1'b0, 4);
    idle(60);

    // Everything predicted must have been written
    idle(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
